gigatron_mem_arb: RTL and testbench
===================================

# gigatron_mem_arb

Memory-port arbiter between the gigatron core and a host agent (loader/debugger). The core uses the shared RAM every cycle and has no wait states, so the arbiter grants the host only by freezing the core through a clock-enable stall. The host then runs byte read/write commands over a valid/ready handshake and releases the RAM when done. The block sits between the core's memory interface (`addr_r`/`addr_w`/`data_i`/`data_o`/`we`) and the RAM: asynchronous read port, synchronous write port.

## Interface
- `MAX_GRANT`, 0: max cycles the host may hold the RAM; 0 = unlimited.
- `clock`  in  1  system clock (core clock domain).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_addr_r`  in  16  core read address.
- `cpu_addr_w`  in  16  core write address.
- `cpu_data_o`  in  8  core write data.
- `cpu_we`  in  1  core write enable.
- `cpu_data_i`  out  8  read data to core.
- `cpu_hold`  out  1  core clock-enable stall; core holds all state while high.
- `host_req`  in  1  host requests RAM ownership (level).
- `host_gnt`  out  1  host owns RAM.
- `host_cmd_valid`  in  1  command present.
- `host_cmd_we`  in  1  1 = write, 0 = read.
- `host_cmd_addr`  in  16  command address.
- `host_cmd_wdata`  in  8  write data.
- `host_cmd_ready`  out  1  command accepted when valid & ready.
- `host_rvalid`  out  1  read data valid (1-cycle pulse).
- `host_rdata`  out  8  read data.
- `host_expired`  out  1  grant revoked by `MAX_GRANT` (sticky until `host_req` low).
- `mem_addr_r`  out  16  RAM read address.
- `mem_addr_w`  out  16  RAM write address.
- `mem_data_w`  out  8  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_data_r`  in  8  RAM read data (combinational).

## Operation
- States: RUN, STALL, GRANT, RESUME.
- RUN:
  - RAM mux selects the core; `mem_*` = `cpu_*` combinationally.
  - `cpu_data_i` = `mem_data_r`.
  - `host_req`=1 -> STALL.
- STALL:
  - `cpu_hold`=1.
  - Mux still selects the core, but `mem_we` is forced 0. A core write presented in the transition cycle was already committed in RUN.
  - Next cycle -> GRANT.
- GRANT:
  - `cpu_hold`=1, `host_gnt`=1, mux selects the host. `host_cmd_ready`=1 (one command per cycle).
  - Write accepted: `mem_we`=1, `mem_addr_w`=`host_cmd_addr`, `mem_data_w`=`host_cmd_wdata` in the same cycle.
  - Read accepted: `mem_addr_r`=`host_cmd_addr`; `mem_data_r` is registered into `host_rdata`; `host_rvalid`=1 next cycle.
  - `host_req`=0 -> RESUME. A command valid in that same cycle is not accepted (`host_cmd_ready`=0).
  - Grant counter (16-bit) counts cycles in GRANT. If `MAX_GRANT`≠0 and counter reaches `MAX_GRANT`-1 -> RESUME and set `host_expired`.
- RESUME:
  - `cpu_hold`=1, mux selects the core, `mem_we`=0. Lets a pending `host_rvalid` complete.
  - Next cycle -> RUN with `cpu_hold`=0.
  - If `host_expired`=1, no new STALL entry until `host_req` has been seen low.
- Idle outputs: `host_cmd_ready`=0 outside GRANT; host-side outputs are ignored by RAM outside GRANT.

## Timing
- Reset (async assert, sync release): state RUN. `cpu_hold`=0, `host_gnt`=0, `host_cmd_ready`=0, `host_rvalid`=0, `host_rdata`=0x00, `host_expired`=0, counter 0.
- Latencies:
  - `host_req` rise -> `host_gnt` high: 2 cycles (STALL, then GRANT).
  - `host_req` fall -> core running (`cpu_hold`=0): 2 cycles.
  - Host write: 0 extra cycles (commits on the accepting edge).
  - Host read: `host_rvalid` 1 cycle after acceptance.
- Address wrap-around is not special: 16-bit address passes unchanged.
- Reset mid-GRANT: returns to RUN immediately; any command in flight is discarded (no `host_rvalid`).
- `host_req` toggling in RESUME is ignored until RUN is reached.

## Configuration
- `MEMARB_READBACK_EN`
  - Defined: host reads supported as above.
  - Undefined: read commands are accepted but have no effect. `host_rvalid` stays 0, `host_rdata` stays 0x00, the read mux leg is removed, and `mem_addr_r` always equals `cpu_addr_r`.

## Test plan
- Core passthrough: no `host_req`, core writes 0x5A to 0x1234 -> RAM[0x1234]=0x5A, `cpu_hold`=0 throughout.
- Grant handshake: `host_req`=1 at cycle N -> `cpu_hold`=1 at N+1, `host_gnt`=1 at N+2; core write in cycle N commits, core write attempt in N+1 does not.
- Host burst: writes 0x11,0x22,0x33 to 0x0100..0x0102 on consecutive cycles, then reads 0x0101 -> `host_rvalid` next cycle with `host_rdata`=0x22.
- Release: `host_req` falls with `host_cmd_valid`=1 -> command not accepted, `cpu_hold` low 2 cycles later, core state unchanged.
- Timeout: `MAX_GRANT`=4, `host_req` held -> exactly 4 GRANT cycles, `host_expired`=1, no re-grant until `host_req` toggles low.
- Async reset during GRANT after a read accepted -> all outputs at reset values immediately, no `host_rvalid` pulse.

Source files
------------

// File: rtl/gigatron_mem_arb.sv
// gigatron_mem_arb: shared-RAM port arbiter between the gigatron core and a host agent
// (loader/debugger). The core has no wait states, so the host is granted the RAM only
// after the core has been frozen through its clock-enable stall (cpu_hold). While granted,
// the host issues one byte read/write command per cycle over a valid/ready handshake.
//
// Parameters:
//   MAX_GRANT     maximum number of cycles the host may hold the RAM; 0 = unlimited.
// Optional feature (macro MEMARB_READBACK_EN):
//   defined   -> host reads return RAM data on host_rdata with a one-cycle host_rvalid pulse.
//   undefined -> read commands are accepted but do nothing; mem_addr_r always follows the core.
//
// Ports:
//   clock, rst_n                       clock, asynchronous active-low reset
//   cpu_addr_r/cpu_addr_w/cpu_data_o/cpu_we, cpu_data_i, cpu_hold   core memory interface
//   host_req/host_gnt                  host ownership request / grant
//   host_cmd_valid/_we/_addr/_wdata/_ready   host command handshake
//   host_rvalid/host_rdata             host read response
//   host_expired                       grant revoked by MAX_GRANT (sticky until host_req low)
//   mem_addr_r/mem_addr_w/mem_data_w/mem_we/mem_data_r   RAM (async read, sync write)

module gigatron_mem_arb #(
  parameter int unsigned MAX_GRANT = 0
) (
  input  logic        clock,
  input  logic        rst_n,
  // core side
  input  logic [15:0] cpu_addr_r,
  input  logic [15:0] cpu_addr_w,
  input  logic [7:0]  cpu_data_o,
  input  logic        cpu_we,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_hold,
  // host side
  input  logic        host_req,
  output logic        host_gnt,
  input  logic        host_cmd_valid,
  input  logic        host_cmd_we,
  input  logic [15:0] host_cmd_addr,
  input  logic [7:0]  host_cmd_wdata,
  output logic        host_cmd_ready,
  output logic        host_rvalid,
  output logic [7:0]  host_rdata,
  output logic        host_expired,
  // RAM side
  output logic [15:0] mem_addr_r,
  output logic [15:0] mem_addr_w,
  output logic [7:0]  mem_data_w,
  output logic        mem_we,
  input  logic [7:0]  mem_data_r
);

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StGrant,
    StResume
  } state_e;

  localparam bit          TimeoutEn = (MAX_GRANT != 0);
  // Last grant cycle index; only meaningful when TimeoutEn is set.
  localparam logic [15:0] GrantLast = TimeoutEn ? 16'(MAX_GRANT - 1) : 16'h0000;

  state_e      state_q, state_d;
  logic [15:0] grant_cnt_q, grant_cnt_d;
  logic        expired_q, expired_d;
  logic        cmd_accept;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    grant_cnt_d    = grant_cnt_q;
    expired_d      = expired_q;
    cpu_hold       = 1'b1;
    host_gnt       = 1'b0;
    host_cmd_ready = 1'b0;

    // Expiry is acknowledged by the host dropping its request.
    if (!host_req) begin
      expired_d = 1'b0;
    end

    unique case (state_q)
      StRun: begin
        cpu_hold = 1'b0;
        if (host_req && !expired_q) begin
          state_d = StStall;
        end
      end
      StStall: begin
        grant_cnt_d = 16'h0000;
        state_d     = StGrant;
      end
      StGrant: begin
        host_gnt    = 1'b1;
        grant_cnt_d = grant_cnt_q + 16'h0001;
        if (!host_req) begin
          // Release cycle: a command presented now is refused.
          state_d = StResume;
        end else begin
          host_cmd_ready = 1'b1;
          if (TimeoutEn && (grant_cnt_q == GrantLast)) begin
            state_d   = StResume;
            expired_d = 1'b1;
          end
        end
      end
      StResume: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      grant_cnt_q <= 16'h0000;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_cnt_q <= grant_cnt_d;
      expired_q   <= expired_d;
    end
  end

  assign host_expired = expired_q;
  assign cmd_accept   = host_cmd_valid & host_cmd_ready;

  // ---------------------------------------------------------------------------
  // RAM port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr_r = cpu_addr_r;
    mem_addr_w = cpu_addr_w;
    mem_data_w = cpu_data_o;
    // Core writes only land while it is actually running; a write shown in the
    // STALL/RESUME cycles belongs to a frozen core and must be dropped.
    mem_we     = cpu_we & (state_q == StRun);
    if (state_q == StGrant) begin
      mem_addr_w = host_cmd_addr;
      mem_data_w = host_cmd_wdata;
      mem_we     = cmd_accept & host_cmd_we;
`ifdef MEMARB_READBACK_EN
      mem_addr_r = host_cmd_addr;
`endif
    end
  end

  assign cpu_data_i = mem_data_r;

  // ---------------------------------------------------------------------------
  // Host read response
  // ---------------------------------------------------------------------------
`ifdef MEMARB_READBACK_EN
  logic       rvalid_q, rvalid_d;
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = cmd_accept & ~host_cmd_we;
    rdata_d  = rvalid_d ? mem_data_r : rdata_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
`else
  assign host_rvalid = 1'b0;
  assign host_rdata  = 8'h00;
`endif

endmodule

// File: tb/tb_gigatron_mem_arb.sv
// Self-checking bench for gigatron_mem_arb: a per-cycle vector table on an unlimited-grant
// instance, then hand sequences for grant timeout (MAX_GRANT=4) and reset during GRANT.
module tb_gigatron_mem_arb;

`ifdef MEMARB_READBACK_EN
  localparam bit Rb = 1'b1;
`else
  localparam bit Rb = 1'b0;
`endif

  logic clock;
  logic rst_n;

  // instance 0 (MAX_GRANT = 0)
  logic [15:0] cpu_addr_r, cpu_addr_w;
  logic [7:0]  cpu_data_o, cpu_data_i;
  logic        cpu_we, cpu_hold;
  logic        host_req, host_gnt, host_cmd_valid, host_cmd_we, host_cmd_ready;
  logic [15:0] host_cmd_addr;
  logic [7:0]  host_cmd_wdata, host_rdata;
  logic        host_rvalid, host_expired;
  logic [15:0] mem_addr_r, mem_addr_w;
  logic [7:0]  mem_data_w, mem_data_r;
  logic        mem_we;
  logic [7:0]  ram0 [0:65535];

  // instance 4 (MAX_GRANT = 4)
  logic        req4, gnt4, hold4, ready4, rvalid4, expired4, we4;
  logic [7:0]  cdi4, rdata4, mdw4, mdr4;
  logic [15:0] mar4, maw4;
  logic [7:0]  ram4 [0:65535];

  int checks = 0;
  int failures = 0;

  gigatron_mem_arb #(.MAX_GRANT(0)) dut0 (
    .clock(clock), .rst_n(rst_n),
    .cpu_addr_r(cpu_addr_r), .cpu_addr_w(cpu_addr_w), .cpu_data_o(cpu_data_o),
    .cpu_we(cpu_we), .cpu_data_i(cpu_data_i), .cpu_hold(cpu_hold),
    .host_req(host_req), .host_gnt(host_gnt), .host_cmd_valid(host_cmd_valid),
    .host_cmd_we(host_cmd_we), .host_cmd_addr(host_cmd_addr),
    .host_cmd_wdata(host_cmd_wdata), .host_cmd_ready(host_cmd_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_expired(host_expired),
    .mem_addr_r(mem_addr_r), .mem_addr_w(mem_addr_w), .mem_data_w(mem_data_w),
    .mem_we(mem_we), .mem_data_r(mem_data_r)
  );

  gigatron_mem_arb #(.MAX_GRANT(4)) dut4 (
    .clock(clock), .rst_n(rst_n),
    .cpu_addr_r(16'h0000), .cpu_addr_w(16'h0000), .cpu_data_o(8'h00),
    .cpu_we(1'b0), .cpu_data_i(cdi4), .cpu_hold(hold4),
    .host_req(req4), .host_gnt(gnt4), .host_cmd_valid(1'b0),
    .host_cmd_we(1'b0), .host_cmd_addr(16'h0000),
    .host_cmd_wdata(8'h00), .host_cmd_ready(ready4),
    .host_rvalid(rvalid4), .host_rdata(rdata4), .host_expired(expired4),
    .mem_addr_r(mar4), .mem_addr_w(maw4), .mem_data_w(mdw4),
    .mem_we(we4), .mem_data_r(mdr4)
  );

  // RAM models: asynchronous read, synchronous write
  assign mem_data_r = ram0[mem_addr_r];
  assign mdr4       = ram4[mar4];
  always @(posedge clock) if (mem_we) ram0[mem_addr_w] <= mem_data_w;
  always @(posedge clock) if (we4) ram4[maw4] <= mdw4;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        req, cv, cwe;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        pwe;
    logic [15:0] paw;
    logic [7:0]  pdo;
    logic        hold, gnt, rdy, mwe;
    logic [15:0] maw;
    logic [7:0]  mdw;
    logic        mar_host, rv;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs [14];
  int   gcount;

  initial begin
    //        req  cv   cwe  caddr     cwd    pwe  paw       pdo    hold gnt  rdy  mwe  maw       mdw    marh rv   rd
    vecs[0]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h2001,8'hEE,1'b0,1'b0,1'b0,1'b1,16'h2001,8'hEE,1'b0,1'b0,8'h00};
    vecs[1]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h0103,8'hAB,1'b0,1'b0,1'b0,1'b1,16'h0103,8'hAB,1'b0,1'b0,8'h00};
    vecs[2]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h2002,8'hCD,1'b0,1'b0,1'b0,1'b1,16'h2002,8'hCD,1'b0,1'b0,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h1234,8'h5A,1'b0,1'b0,1'b0,1'b1,16'h1234,8'h5A,1'b0,1'b0,8'h00};
    // host_req rises (cycle N): core write still commits
    vecs[4]  = '{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h2000,8'h77,1'b0,1'b0,1'b0,1'b1,16'h2000,8'h77,1'b0,1'b0,8'h00};
    // STALL (N+1): core write suppressed
    vecs[5]  = '{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h2001,8'h66,1'b1,1'b0,1'b0,1'b0,16'h2001,8'h66,1'b0,1'b0,8'h00};
    // GRANT (N+2): host burst, core write ignored
    vecs[6]  = '{1'b1,1'b1,1'b1,16'h0100,8'h11,1'b1,16'h2001,8'h66,1'b1,1'b1,1'b1,1'b1,16'h0100,8'h11,1'b1,1'b0,8'h00};
    vecs[7]  = '{1'b1,1'b1,1'b1,16'h0101,8'h22,1'b0,16'h0000,8'h00,1'b1,1'b1,1'b1,1'b1,16'h0101,8'h22,1'b1,1'b0,8'h00};
    vecs[8]  = '{1'b1,1'b1,1'b1,16'h0102,8'h33,1'b0,16'h0000,8'h00,1'b1,1'b1,1'b1,1'b1,16'h0102,8'h33,1'b1,1'b0,8'h00};
    vecs[9]  = '{1'b1,1'b1,1'b0,16'h0101,8'h00,1'b0,16'h0000,8'h00,1'b1,1'b1,1'b1,1'b0,16'h0101,8'h00,1'b1,1'b0,8'h00};
    vecs[10] = '{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0000,8'h00,1'b1,1'b1,1'b1,1'b0,16'h0000,8'h00,1'b1,Rb,
                 Rb ? 8'h22 : 8'h00};
    // release with a write pending: refused
    vecs[11] = '{1'b0,1'b1,1'b1,16'h0103,8'h44,1'b0,16'h0000,8'h00,1'b1,1'b1,1'b0,1'b0,16'h0103,8'h44,1'b1,1'b0,
                 Rb ? 8'h22 : 8'h00};
    // RESUME: core still held, its write dropped
    vecs[12] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h2002,8'h88,1'b1,1'b0,1'b0,1'b0,16'h2002,8'h88,1'b0,1'b0,
                 Rb ? 8'h22 : 8'h00};
    // RUN again
    vecs[13] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0000,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,
                 Rb ? 8'h22 : 8'h00};

    rst_n = 1'b0;
    cpu_addr_r = 16'h1234; cpu_addr_w = 16'h0000; cpu_data_o = 8'h00; cpu_we = 1'b0;
    host_req = 1'b0; host_cmd_valid = 1'b0; host_cmd_we = 1'b0;
    host_cmd_addr = 16'h0000; host_cmd_wdata = 8'h00; req4 = 1'b0;

    #2;
    chk("rst_hold", cpu_hold, 0);
    chk("rst_gnt", host_gnt, 0);
    chk("rst_ready", host_cmd_ready, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 8'h00);
    chk("rst_expired", host_expired, 0);
    chk("rst_hold4", hold4, 0);
    chk("rst_expired4", expired4, 0);
    #10 rst_n = 1'b1;
    tick();

    // ---------------- vector table on instance 0 ----------------
    for (int i = 0; i < 14; i++) begin
      host_req = vecs[i].req; host_cmd_valid = vecs[i].cv; host_cmd_we = vecs[i].cwe;
      host_cmd_addr = vecs[i].caddr; host_cmd_wdata = vecs[i].cwd;
      cpu_we = vecs[i].pwe; cpu_addr_w = vecs[i].paw; cpu_data_o = vecs[i].pdo;
      @(negedge clock);
      chk($sformatf("v%0d_hold", i), cpu_hold, vecs[i].hold);
      chk($sformatf("v%0d_gnt", i), host_gnt, vecs[i].gnt);
      chk($sformatf("v%0d_ready", i), host_cmd_ready, vecs[i].rdy);
      chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].mwe);
      chk($sformatf("v%0d_addr_w", i), mem_addr_w, vecs[i].maw);
      chk($sformatf("v%0d_data_w", i), mem_data_w, vecs[i].mdw);
      chk($sformatf("v%0d_addr_r", i), mem_addr_r,
          (vecs[i].mar_host && Rb) ? vecs[i].caddr : 16'h1234);
      chk($sformatf("v%0d_rvalid", i), host_rvalid, vecs[i].rv);
      chk($sformatf("v%0d_rdata", i), host_rdata, vecs[i].rd);
      tick();
    end

    chk("ram_2001_stall_drop", ram0[16'h2001], 8'hEE);
    chk("ram_2000_core_n", ram0[16'h2000], 8'h77);
    chk("ram_1234_core", ram0[16'h1234], 8'h5A);
    chk("ram_0100_host", ram0[16'h0100], 8'h11);
    chk("ram_0101_host", ram0[16'h0101], 8'h22);
    chk("ram_0102_host", ram0[16'h0102], 8'h33);
    chk("ram_0103_release_drop", ram0[16'h0103], 8'hAB);
    chk("ram_2002_resume_drop", ram0[16'h2002], 8'hCD);
    chk("cpu_data_i", cpu_data_i, 8'h5A);

    // ---------------- timeout on instance 4 ----------------
    req4 = 1'b1;
    gcount = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (gnt4) gcount++;
      if (i == 1) chk("to_stall_hold", hold4, 1);
      if (i == 6) begin
        chk("to_resume_hold", hold4, 1);
        chk("to_resume_expired", expired4, 1);
      end
      tick();
    end
    chk("to_grant_cycles", gcount, 4);
    chk("to_no_regrant_hold", hold4, 0);
    chk("to_expired_sticky", expired4, 1);
    req4 = 1'b0;
    @(negedge clock);
    chk("to_expired_until_low", expired4, 1);
    tick();
    req4 = 1'b1;
    @(negedge clock);
    chk("to_expired_cleared", expired4, 0);
    tick();
    @(negedge clock);
    chk("to_restall", hold4, 1);
    tick();
    @(negedge clock);
    chk("to_regrant", gnt4, 1);
    tick();
    req4 = 1'b0;
    tick(); tick(); tick();

    // ---------------- reset during GRANT with a read accepted ----------------
    host_req = 1'b1; host_cmd_valid = 1'b0;
    tick(); tick();
    host_cmd_valid = 1'b1; host_cmd_we = 1'b0; host_cmd_addr = 16'h0100;
    @(negedge clock);
    chk("mr_gnt", host_gnt, 1);
    chk("mr_ready", host_cmd_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_hold", cpu_hold, 0);
    chk("mr_gnt_low", host_gnt, 0);
    chk("mr_ready_low", host_cmd_ready, 0);
    chk("mr_rvalid", host_rvalid, 0);
    chk("mr_rdata", host_rdata, 8'h00);
    host_req = 1'b0; host_cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("mr_post%0d_rvalid", i), host_rvalid, 0);
      chk($sformatf("mr_post%0d_hold", i), cpu_hold, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
